// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clk.
// An operand pair is accepted in IDLE, added over WIDTH RUN cycles, and
// the result is held in DONE until the consumer takes it.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for in_valid; in_ready high
// RUN    | shifting one bit per cycle through the full adder
// DONE   | sum/carry_out presented, out_valid high until out_ready
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_r;
   logic [WIDTH-1:0] sum_next;
   logic             carry_r;
   logic             s_bit;
   logic             c_next;
   logic [CW-1:0]    cnt;

   // Full-adder cell on the current LSBs; new sum bit enters at the MSB.
   always_comb begin
      s_bit    = a_sr[0] ^ b_sr[0] ^ carry_r;
      c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_r) | (b_sr[0] & carry_r);
      sum_next = sum_r >> 1;
      sum_next[WIDTH-1] = s_bit;
   end

   // Control FSM plus operand/sum shift registers and the carry register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         a_sr    <= '0;
         b_sr    <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_sr    <= a;
                  b_sr    <= b;
                  carry_r <= carry_in;
                  sum_r   <= '0;
                  cnt     <= '0;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               sum_r   <= sum_next;
               carry_r <= c_next;
               cnt     <= cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // After the last RUN bit the carry register holds the final carry out.
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_RUN) || (state == S_DONE);
   assign sum       = sum_r;
   assign carry_out = carry_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): stimulus pushes expected
// {carry_out,sum} into a queue, a monitor pops on every output handshake.
`timescale 1ns/1ns
module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       carry_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       carry_out;
   logic       busy;

   int n_tests  = 0;
   int n_fail   = 0;
   int n_pushed = 0;
   int n_popped = 0;
   int cyc      = 0;
   int last_hs  = -1;
   bit b2b_mode = 0;
   bit rnd_mode = 0;
   bit held_valid = 0;
   logic [8:0] held;
   logic [8:0] exp_q[$];

   serial_adder #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Random consumer backpressure during the regression phase.
   always @(negedge clk) begin
      if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: samples 2 ns after the falling edge, well away from posedge.
   always begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
         held_valid = 0;
      end else begin
         check("in_ready_vs_busy", {31'd0, in_ready}, {31'd0, ~busy});
         if (out_valid) begin
            if (held_valid) check("hold_result", {23'd0, carry_out, sum}, {23'd0, held});
            if (out_ready) begin
               held_valid = 0;
               if (exp_q.size() == 0) begin
                  check("unexpected_result", {23'd0, carry_out, sum}, 32'hFFFF_FFFF);
               end else begin
                  check("result", {23'd0, carry_out, sum}, {23'd0, exp_q.pop_front()});
                  n_popped++;
               end
               if (b2b_mode && last_hs >= 0) check("b2b_spacing", cyc - last_hs, 10);
               last_hs = cyc;
            end else begin
               held = {carry_out, sum};
               held_valid = 1;
            end
         end
      end
   end

   // Called at a falling edge; waits for in_ready, presents one op for one cycle.
   task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input bit push, input logic [8:0] ex);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("issue_timeout", 32'd0, 32'd1);
         return;
      end
      a = ia; b = ib; carry_in = ic; in_valid = 1'b1;
      if (push) begin
         exp_q.push_back(ex);
         n_pushed++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); carry_in = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   logic [7:0] va [10] = '{8'h12, 8'h80, 8'h7F, 8'h00, 8'hAA, 8'hAA, 8'hC3, 8'h01, 8'hF0, 8'h99};
   logic [7:0] vb [10] = '{8'h34, 8'h80, 8'h01, 8'h00, 8'h55, 8'h55, 8'h3C, 8'h02, 8'h0F, 8'h77};
   logic       vc [10] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
   logic [8:0] ve [10] = '{9'h046, 9'h100, 9'h080, 9'h001, 9'h0FF, 9'h100, 9'h100, 9'h004, 9'h0FF, 9'h110};

   initial begin
      bit ok;
      int n;
      logic [7:0] ra, rb;
      logic rc;

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b1;
      #3;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_sum", {23'd0, carry_out, sum}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Latency/busy window for 5A+3C.
      issue(8'h5A, 8'h3C, 1'b0, 1, 9'h096);
      ok = 1;
      check("busy_at_accept", {31'd0, busy}, 32'd1);
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || busy !== 1'b1) ok = 0;
      end
      check("run_window", {31'd0, ok}, 32'd1);
      @(negedge clk);
      check("latency_out_valid", {31'd0, out_valid}, 32'd1);
      check("latency_busy", {31'd0, busy}, 32'd1);
      check("latency_sum", {23'd0, carry_out, sum}, 32'h096);
      drain();
      @(negedge clk);

      issue(8'hFF, 8'h01, 1'b0, 1, 9'h100);
      issue(8'hFF, 8'hFF, 1'b1, 1, 9'h1FF);
      drain();
      @(negedge clk);

      // Backpressure: DONE held 5 cycles while new operands toggle.
      out_ready = 1'b0;
      issue(8'hA7, 8'h6B, 1'b1, 1, 9'h113);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bp_reach_done", {31'd0, out_valid}, 32'd1);
      ok = 1;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); carry_in = 1'($urandom);
         @(negedge clk);
         if (in_ready !== 1'b0 || out_valid !== 1'b1) ok = 0;
      end
      check("bp_in_ready_low", {31'd0, ok}, 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      issue(8'h11, 8'h22, 1'b0, 1, 9'h033);
      drain();
      @(negedge clk);

      // Reset mid-RUN: 12+34 discarded, no result may appear.
      issue(8'h12, 8'h34, 1'b0, 0, 9'h000);
      repeat (4) @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrun_rst_sum", {23'd0, carry_out, sum}, 32'd0);
      check("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      ok = 1;
      repeat (12) begin
         @(negedge clk);
         if (out_valid !== 1'b0) ok = 0;
      end
      check("no_pulse_after_rst", {31'd0, ok}, 32'd1);
      issue(8'h80, 8'h80, 1'b0, 1, 9'h100);
      drain();
      @(negedge clk);

      // Back-to-back, out_ready tied high: results every 10 cycles.
      last_hs = -1;
      b2b_mode = 1;
      for (int i = 0; i < 10; i++) issue(va[i], vb[i], vc[i], 1, ve[i]);
      drain();
      b2b_mode = 0;
      @(negedge clk);

      // Random regression against the 9-bit reference sum.
      rnd_mode = 1;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         issue(ra, rb, rc, 1, {1'b0, ra} + {1'b0, rb} + {8'd0, rc});
      end
      rnd_mode = 0;
      @(negedge clk);
      out_ready = 1'b1;
      drain();
      check("txn_count", n_popped, n_pushed);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; legal range is 1 to 32.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair and carry_in are valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 carry_in  input  1  initial carry.
REQ-009 out_valid  output  1  sum and carry_out are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  WIDTH  result, a+b+carry_in modulo 2^WIDTH.
REQ-012 carry_out  output  1  carry out of bit WIDTH-1.
REQ-013 busy  output  1  high while the FSM is in state RUN or DONE.

Function
REQ-014 The datapath SHALL be bit-serial: one full-adder cell, LSB first, one bit per clock, with a 1-bit carry register between cycles.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 if and only if the state is IDLE; out_valid SHALL be 1 if and only if the state is DONE.
REQ-017 IDLE, edge with in_valid=1: the block SHALL load a and b into shift registers, load carry_in into the carry register, clear the bit counter and sum register, and go to RUN.
REQ-018 IDLE, edge with in_valid=0: the block SHALL stay in IDLE, and all registers SHALL hold their values.
REQ-019 RUN, each edge:
- compute s = A[0]^B[0]^c and the new carry = majority(A[0],B[0],c);
- shift A and B right by one;
- shift s into sum at the MSB, shifting sum right;
- update the carry register;
- increment the counter.
REQ-020 RUN SHALL go to DONE on the edge where the counter equals WIDTH-1, so RUN lasts exactly WIDTH cycles.
REQ-021 out_valid SHALL rise exactly WIDTH clock edges after the accepting edge.
REQ-022 On that edge, sum SHALL equal (a+b+carry_in) mod 2^WIDTH and carry_out SHALL equal bit WIDTH of a+b+carry_in.
REQ-023 DONE: sum and carry_out SHALL stay stable until an edge with out_ready=1, on which the block SHALL go to IDLE.
REQ-024 In DONE, out_valid SHALL remain high indefinitely while out_ready=0.
REQ-025 in_valid SHALL be ignored in RUN and DONE, with no buffering or queuing of operands.
REQ-026 When WIDTH=1, RUN SHALL last one cycle and the result SHALL be the plain full-adder output.
REQ-027 Minimum issue interval SHALL be WIDTH+2 cycles: one accept cycle, WIDTH RUN cycles, one DONE cycle with out_ready=1.
REQ-028 The operands SHALL be captured on the accepting edge; later changes on a, b or carry_in SHALL NOT affect the result.
REQ-029 Outside DONE, the values on sum and carry_out are don't-care, except at reset.
REQ-030 The counter SHALL be clog2(WIDTH)+1 bits wide and SHALL never wrap in legal operation.

Reset
REQ-031 While rst_n=0, all of the following SHALL hold:
- state = IDLE;
- out_valid=0, busy=0;
- sum=0, carry_out=0;
- counter=0, carry register=0, operand registers=0.
REQ-032 Reset SHALL take effect immediately, regardless of clk, including mid-RUN and in DONE; the partial result SHALL be discarded and no out_valid pulse SHALL follow.
REQ-033 After rst_n rises, in_ready SHALL be 1 and the first in_valid edge SHALL be accepted normally.

Verification (WIDTH=8)
REQ-034 a=8'h5A, b=8'h3C, carry_in=0, accepted at edge E -> at edge E+8: out_valid=1, sum=8'h96, carry_out=0; busy=1 from E to E+8.
REQ-035 a=8'hFF, b=8'h01, carry_in=0 -> sum=8'h00, carry_out=1; a=8'hFF, b=8'hFF, carry_in=1 -> sum=8'hFF, carry_out=1.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands toggling -> sum and carry_out held, in_ready=0, and the next accepted op is the one presented after the out_ready handshake.
REQ-037 rst_n pulsed low for 1 ns after 4 RUN cycles of 8'h12+8'h34 -> out_valid stays 0, sum=0, in_ready=1; the next op 8'h80+8'h80 gives sum=8'h00, carry_out=1.
REQ-038 Back-to-back ops with out_ready tied to 1 -> out_valid pulses one cycle each, 10 cycles apart, and every result is correct against a+b+carry_in.
REQ-039 Random regression: at least 1000 random (a, b, carry_in) triples with random in_valid and out_ready -> every result matches the reference sum, with no lost or duplicated transactions.
